// File: rtl/rand_range_sampler.sv
// rand_range_sampler: draws NBITS random values from random_num_gen and
// accepts the first one with 0 < r < modulus, retrying up to MAX_TRIES times.
// The range check is word-serial, WBITS per cycle, MSB word first.
// Optional build macro RAND_SAMPLER_STATS_EN adds the attempts / reject_total
// statistics outputs.
module rand_range_sampler #(
  parameter int NBITS     = 2048,
  parameter int WBITS     = 64,
  parameter int MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic [11:0]      maxbits,
  input  logic [NBITS-1:0] modulus,
  output logic             rng_enable_p,
  output logic [11:0]      rng_maxbits,
  input  logic             rng_done_p,
  input  logic [NBITS-1:0] rng_y,
  output logic             busy,
  output logic             done_p,
  output logic             err,
  output logic [NBITS-1:0] r
`ifdef RAND_SAMPLER_STATS_EN
  ,
  output logic [7:0]       attempts,
  output logic [15:0]      reject_total
`endif
);

  localparam int NW   = NBITS / WBITS;
  localparam int IDXW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NW - 1);
  localparam logic [7:0]      TRIES   = 8'(MAX_TRIES);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_CMP, S_DECIDE, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_EQ, C_LT, C_GT
  } cmp_t;

  state_t            state_q, state_d;
  cmp_t              cmp_q, cmp_d;
  logic [NBITS-1:0]  cand_q, cand_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              nz_q, nz_d;
  logic [7:0]        tries_q, tries_d;
  logic [11:0]       maxbits_q, maxbits_d;
  logic              err_q, err_d;
  logic [NBITS-1:0]  r_q, r_d;

  logic [WBITS-1:0]  cand_word;
  logic [WBITS-1:0]  mod_word;
  logic [NBITS-1:0]  cand_rot;
  logic              accept;

  // Current comparison words: the candidate's MSB word is always on top
  // because the register rotates; the modulus word is picked by index.
  always_comb begin
    cand_word = cand_q[NBITS-1 -: WBITS];
    mod_word  = modulus[idx_q*WBITS +: WBITS];
    cand_rot  = (cand_q << WBITS) | (cand_q >> (NBITS - WBITS));
    accept    = (cmp_q == C_LT) && nz_q;
  end

  // Next-state and datapath update for the sampling sequence.
  always_comb begin
    state_d   = state_q;
    cmp_d     = cmp_q;
    cand_d    = cand_q;
    idx_d     = idx_q;
    nz_d      = nz_q;
    tries_d   = tries_q;
    maxbits_d = maxbits_q;
    err_d     = err_q;
    r_d       = r_q;
    case (state_q)
      S_IDLE: begin
        if (start_p) begin
          maxbits_d = maxbits;
          err_d     = 1'b0;
          tries_d   = 8'd0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // Saturating: the DECIDE gate keeps this at or below MAX_TRIES anyway.
        if (tries_q < TRIES) tries_d = tries_q + 8'd1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rng_done_p) begin
          cand_d  = rng_y;
          idx_d   = IDX_MSB;
          cmp_d   = C_EQ;
          nz_d    = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        nz_d = nz_q | (cand_word != '0);
        // The first differing word from the top decides; later words cannot change it.
        if (cmp_q == C_EQ) begin
          if (cand_word < mod_word)      cmp_d = C_LT;
          else if (cand_word > mod_word) cmp_d = C_GT;
        end
        cand_d = cand_rot;
        if (idx_q == '0) state_d = S_DECIDE;
        else             idx_d   = idx_q - 1'b1;
      end
      S_DECIDE: begin
        if (accept) begin
          r_d     = cand_q;
          state_d = S_DONE;
        end else if (tries_q < TRIES) begin
          state_d = S_REQ;
        end else begin
          r_d     = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmp_q     <= C_EQ;
      cand_q    <= '0;
      idx_q     <= '0;
      nz_q      <= 1'b0;
      tries_q   <= 8'd0;
      maxbits_q <= 12'd0;
      err_q     <= 1'b0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      cmp_q     <= cmp_d;
      cand_q    <= cand_d;
      idx_q     <= idx_d;
      nz_q      <= nz_d;
      tries_q   <= tries_d;
      maxbits_q <= maxbits_d;
      err_q     <= err_d;
      r_q       <= r_d;
    end
  end

  // Control outputs decoded straight from the state register.
  always_comb begin
    rng_enable_p = (state_q == S_REQ);
    done_p       = (state_q == S_DONE);
    busy         = (state_q == S_REQ) || (state_q == S_WAIT) ||
                   (state_q == S_CMP) || (state_q == S_DECIDE);
    rng_maxbits  = maxbits_q;
    err          = err_q;
    r            = r_q;
  end

`ifdef RAND_SAMPLER_STATS_EN
  logic [15:0] rej_total_q, rej_total_d;

  // Saturating count of every rejected draw since reset.
  always_comb begin
    rej_total_d = rej_total_q;
    if ((state_q == S_DECIDE) && !accept && (rej_total_q != 16'hFFFF))
      rej_total_d = rej_total_q + 16'd1;
  end

  // Rejection counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rej_total_q <= 16'd0;
    else        rej_total_q <= rej_total_d;
  end

  // The attempt counter already holds its final value from done_p until the next start_p.
  always_comb begin
    attempts     = tries_q;
    reject_total = rej_total_q;
  end
`endif

endmodule

// File: doc/rand_range_sampler.md
Name: rand_range_sampler

Overview:
- Downstream consumer of random_num_gen in the crypto_lib datapath.
- Requests an NBITS random value from the generator and checks it against the public modulus N. Accepts only values with 0 < r < N.
- Rejected values trigger a new request, up to MAX_TRIES attempts in total.
- Feeds r into the Paillier encryption path (g^m * r^N mod N^2). The comparison is word-serial to keep area small at NBITS=2048.

Parameters:
- NBITS, 2048, operand width of the random value and the modulus.
- WBITS, 64, comparator word width; NBITS must be an integer multiple of WBITS.
- MAX_TRIES, 8, maximum random draws per start_p before reporting an error; range 1..255.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_p  input  1  one-cycle pulse that starts a sampling operation
- maxbits  input  12  bit length forwarded to the generator
- modulus  input  NBITS  N; the upstream must hold it stable while busy=1
- rng_enable_p  output  1  one-cycle request pulse to random_num_gen enable_p
- rng_maxbits  output  12  registered copy of maxbits, connected to random_num_gen maxbits
- rng_done_p  input  1  random_num_gen done_p
- rng_y  input  NBITS  random_num_gen y
- busy  output  1  high from the cycle after an accepted start_p until done_p
- done_p  output  1  one-cycle completion pulse
- err  output  1  high with done_p when all MAX_TRIES draws were rejected; holds until the next start_p
- r  output  NBITS  accepted random value; valid from done_p until the next start_p

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal registers and attempt counter 0.
- FSM states: IDLE, REQ, WAIT, CMP, DECIDE, DONE.
- IDLE:
  - On start_p: latch maxbits into rng_maxbits, clear err and attempt count, go to REQ.
  - start_p is ignored in every other state.
- REQ:
  - Assert rng_enable_p for exactly one cycle, increment the attempt count, go to WAIT.
  - For start_p at cycle 0, rng_enable_p is high at cycle 1.
- WAIT:
  - On rng_done_p, capture rng_y into the candidate shift register in that same cycle.
  - Reset the word index to the MSB word, set cmp_state=EQ and nz=0, go to CMP.
  - rng_done_p in any state other than WAIT is ignored.
- CMP: one WBITS word per cycle, MSB word first, for exactly NBITS/WBITS cycles.
  - nz |= (word != 0).
  - While cmp_state=EQ: candidate word < modulus word sets LT; greater sets GT; equal keeps EQ.
  - Once LT or GT is set it is frozen.
  - The candidate register rotates, so its contents are intact after the last word. After the last word, go to DECIDE.
- DECIDE:
  - Accept when cmp_state=LT and nz=1: r <= candidate, go to DONE.
  - Reject when GT, EQ, or nz=0:
    - If attempts < MAX_TRIES, go to REQ (new pulse on the next cycle).
    - Otherwise r <= 0, err <= 1, go to DONE.
- DONE: pulse done_p for one cycle, busy falls in the same cycle, return to IDLE.
- Latency, single accepted draw: done_p occurs G + NBITS/WBITS + 3 cycles after start_p, where G = generator latency from enable_p to rng_done_p.
- Attempt counter width is 8 bits and never wraps: max value MAX_TRIES.
- Asynchronous reset in any state: immediate return to IDLE with all outputs 0. A pending generator result is then dropped; a late rng_done_p arriving in IDLE is ignored.
- Degenerate modulus: modulus=0 or modulus=1 can never accept, so the block always terminates with err=1 after MAX_TRIES draws.

Optional Feature:
- Macro: RAND_SAMPLER_STATS_EN.
- When defined:
  - Adds output port attempts [7:0], holding the number of draws used by the last operation; valid with done_p and held until the next start_p.
  - Adds output port reject_total [15:0], a saturating count of all rejections since reset.
- When undefined: neither port exists and no counter logic beyond the internal attempt counter is built.

Test Plan (bench config NBITS=16, WBITS=4, MAX_TRIES=3, generator modelled with G=5):
- modulus=0x8001, rng_y=0x1234 -> one rng_enable_p; done_p 12 cycles after start_p; r=0x1234; err=0.
- modulus=0x8001, draws 0x9000 then 0x0042 -> two rng_enable_p pulses; r=0x0042; err=0; attempts=2 (macro on).
- modulus=0x8001, draws 0x8001 (equal), then 0x0000 (zero), then 0x8000 -> first two rejected, r=0x8000, attempts=3.
- modulus=0x0100, draws 0xFFFF, 0x0100, 0x0000 -> done_p with err=1, r=0x0000; reject_total=3 (macro on).
- start_p repeated during WAIT, plus spurious rng_done_p in IDLE -> single operation, no extra rng_enable_p, result unchanged.
- rst_n asserted mid-CMP, then released, then start_p with draw 0x0001 on modulus=0x0002 -> all outputs 0 during reset; next op returns r=0x0001, err=0.
